// File: rtl/plot_defs.sv
// Shared constants for the sprite plotter: sprite sizes, colours, lane geometry
// and the press-position to lane table.
package plot_defs;

    localparam int PRESS_WIDTH  = 40;
    localparam int PRESS_HEIGHT = 60;
    localparam int GARB_WIDTH   = 20;
    localparam int GARB_HEIGHT  = 20;
    localparam int GARB_TOP     = 100;
    localparam int LANE_STEP    = 40;
    localparam int GARB_INSET   = 10;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_PRESS = 3'b111;
    localparam logic [2:0] COLOUR_GARB  = 3'b010;

    localparam logic [2:0] PRESS_POS_MAX = 3'd5;
    localparam logic [2:0] GARB_LANE_MAX = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLOT,
        ST_DONE
    } state_t;

    // The press sweeps lanes 0..3 and back again across positions 0..5.
    function automatic logic [1:0] press_lane(input logic [2:0] position);
        case (position)
            3'd0:    press_lane = 2'd0;
            3'd1:    press_lane = 2'd1;
            3'd2:    press_lane = 2'd2;
            3'd3:    press_lane = 2'd3;
            3'd4:    press_lane = 2'd2;
            3'd5:    press_lane = 2'd1;
            default: press_lane = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y offset counter over a width x height window; last flags the
// final pixel and the count holds there until the next load.
module raster_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] x_off,
    output logic [6:0] y_off,
    output logic       last
);

    logic row_end;

    assign row_end = (x_off == width - 8'd1);
    assign last    = row_end && (y_off == height - 7'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_off <= '0;
            y_off <= '0;
        end else if (load) begin
            x_off <= '0;
            y_off <= '0;
        end else if (step) begin
            if (row_end) begin
                x_off <= '0;
                y_off <= y_off + 7'd1;
            end else begin
                x_off <= x_off + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// Draws or erases the press / garbage sprite on a 160x120 VGA adapter, one
// pixel per cycle, with an IDLE/PLOT/DONE request handshake.
module sprite_plotter
    import plot_defs::*;
#(
    parameter int PRESS_W = PRESS_WIDTH,
    parameter int PRESS_H = PRESS_HEIGHT,
    parameter int GARB_W  = GARB_WIDTH,
    parameter int GARB_H  = GARB_HEIGHT,
    parameter int GARB_Y  = GARB_TOP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_item,
    input  logic       req_erase,
    input  logic [2:0] req_position,
    output logic       req_ready,
    output logic       done,
    output logic       error,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    state_t     state, state_next;
    logic       accept, legal, load;
    logic [1:0] lane;
    logic       err_q;
    logic [7:0] origin_x, win_w, x_off;
    logic [6:0] origin_y, win_h, y_off;
    logic       last;

    assign accept = req_valid && (state == ST_IDLE);
    assign legal  = req_item ? (req_position <= PRESS_POS_MAX)
                             : (req_position <= GARB_LANE_MAX);
    assign lane   = req_item ? press_lane(req_position) : req_position[1:0];
    assign load   = accept && legal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        plot       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) state_next = legal ? ST_PLOT : ST_DONE;
            end
            ST_PLOT: begin
                plot = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                error      = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request fields are captured once at accept; x/y/colour keep their last
    // values through an out-of-range request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q    <= 1'b0;
            colour   <= COLOUR_BLACK;
            origin_x <= '0;
            origin_y <= '0;
            win_w    <= '0;
            win_h    <= '0;
        end else begin
            if (accept) err_q <= !legal;
            if (load) begin
                origin_x <= {6'd0, lane} * 8'(LANE_STEP) + (req_item ? 8'd0 : 8'(GARB_INSET));
                origin_y <= req_item ? 7'd0 : 7'(GARB_Y);
                win_w    <= req_item ? 8'(PRESS_W) : 8'(GARB_W);
                win_h    <= req_item ? 7'(PRESS_H) : 7'(GARB_H);
                colour   <= req_erase ? COLOUR_BLACK : (req_item ? COLOUR_PRESS : COLOUR_GARB);
            end
        end
    end

    raster_counter u_raster (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (plot && !last),
        .width  (win_w),
        .height (win_h),
        .x_off  (x_off),
        .y_off  (y_off),
        .last   (last)
    );

    assign x = origin_x + x_off;
    assign y = origin_y + y_off;

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomized and directed bench for sprite_plotter against a pixel-list model
// derived from the sprite geometry rules.
module tb_sprite_plotter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_item = 1'b0;
    logic       req_erase = 1'b0;
    logic [2:0] req_position = 3'd0;
    logic       req_ready, done, error, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_cmp = 0;
    int n_bad = 0;
    int lane_tab[6] = '{0, 1, 2, 3, 2, 1};
    logic [7:0] x_prev;
    logic [6:0] y_prev;

    sprite_plotter dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_item     (req_item),
        .req_erase    (req_erase),
        .req_position (req_position),
        .req_ready    (req_ready),
        .done         (done),
        .error        (error),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for req_ready, presents the request and returns just
    // after the accepting rising edge.
    task automatic issue(input logic item, input logic erase, input logic [2:0] pos);
        int waited = 0;
        while (!req_ready && waited < 3000) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        req_item     = item;
        req_erase    = erase;
        req_position = pos;
        req_valid    = 1'b1;
        x_prev       = x;
        y_prev       = y;
        @(posedge clock);
    endtask

    // Samples every cycle after accept and compares against the expected
    // pixel list. With hold set, req_valid stays high with scrambled fields
    // and the next request's fields are presented once done is seen.
    task automatic collect(input logic item, input logic erase, input logic [2:0] pos,
                           input bit hold, input logic nitem, input logic nerase,
                           input logic [2:0] npos);
        bit legal = item ? (pos <= 5) : (pos <= 3);
        int lane  = !legal ? 0 : (item ? lane_tab[pos] : int'(pos));
        int w     = item ? 40 : 20;
        int h     = item ? 60 : 20;
        int ox    = lane * 40 + (item ? 0 : 10);
        int oy    = item ? 0 : 100;
        int n     = legal ? w * h : 0;
        int col   = erase ? 0 : (item ? 7 : 2);
        int np = 0, pix_bad = 0, col_bad = 0, stray = 0, done_cyc = -1;
        int fx = -1, fy = -1, lx = -1, ly = -1;
        bit got_done = 0, err_seen = 0;
        for (int cyc = 1; cyc <= n + 4 && !got_done; cyc++) begin
            @(negedge clock);
            if (!hold && cyc == 1) req_valid = 1'b0;
            if (hold) begin
                req_item     = 1'($urandom);
                req_erase    = 1'($urandom);
                req_position = 3'($urandom);
            end
            if (plot) begin
                if (int'(x) != ox + np % w || int'(y) != oy + np / w) pix_bad++;
                if (int'(colour) != col) col_bad++;
                if (np == 0) begin fx = x; fy = y; end
                lx = x; ly = y;
                np++;
            end
            if (req_ready) stray++;
            if (error && !done) stray++;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                err_seen = error;
                if (plot) stray++;
                if (hold) begin
                    req_item     = nitem;
                    req_erase    = nerase;
                    req_position = npos;
                end
            end
        end
        check("plot_count", np, n);
        check("done_cycle", done_cyc, n + 1);
        check("error_flag", err_seen, !legal);
        check("pixel_seq_errors", pix_bad, 0);
        check("colour_errors", col_bad, 0);
        check("stray_handshake", stray, 0);
        if (n > 0) begin
            check("first_x", fx, ox);
            check("first_y", fy, oy);
            check("last_x", lx, ox + w - 1);
            check("last_y", ly, oy + h - 1);
            check("last_in_screen", (lx <= 159 && ly <= 119), 1);
        end
        @(negedge clock);
        check("ready_after_done", req_ready, 1);
        check("done_single_pulse", done, 0);
        check("x_hold", x, n > 0 ? 32'(ox + w - 1) : 32'(x_prev));
        check("y_hold", y, n > 0 ? 32'(oy + h - 1) : 32'(y_prev));
        check("plot_idle", plot, 0);
    endtask

    task automatic run(input logic item, input logic erase, input logic [2:0] pos);
        issue(item, erase, pos);
        collect(item, erase, pos, 0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        int plots;
        repeat (3) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        reset = 1'b0;
        @(negedge clock);

        run(1'b1, 1'b0, 3'd0);   // press draw, lane 0
        run(1'b1, 1'b1, 3'd4);   // press erase, position 4 -> lane 2
        run(1'b0, 1'b0, 3'd3);   // garbage draw, lane 3
        run(1'b0, 1'b0, 3'd5);   // garbage out of range
        run(1'b1, 1'b0, 3'd6);   // press out of range
        run(1'b1, 1'b0, 3'd5);   // press last legal position -> lane 1

        // Valid held through PLOT with changing fields; next request is fresh.
        issue(1'b0, 1'b0, 3'd1);
        collect(1'b0, 1'b0, 3'd1, 1, 1'b1, 1'b1, 3'd3);
        issue(1'b1, 1'b1, 3'd3);
        collect(1'b1, 1'b1, 3'd3, 0, 1'b0, 1'b0, 3'd0);

        // Reset on plot cycle 100 of a press draw.
        issue(1'b1, 1'b0, 3'd2);
        plots = 0;
        for (int cyc = 0; cyc < 200 && plots < 100; cyc++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (plot) plots++;
        end
        check("plots_before_reset", plots, 100);
        reset = 1'b1;
        #1;
        check("abort_plot", plot, 0);
        check("abort_done", done, 0);
        check("abort_ready", req_ready, 1);
        check("abort_x", x, 0);
        check("abort_y", y, 0);
        check("abort_colour", colour, 0);
        @(negedge clock);
        check("abort_no_done", done, 0);
        #3;
        reset = 1'b0;
        run(1'b0, 1'b1, 3'd2);   // accepted on the first edge after release

        for (int i = 0; i < 8; i++) begin
            logic       it  = 1'($urandom);
            logic       er  = 1'($urandom);
            logic [2:0] pos = 3'($urandom_range(0, 7));
            run(it, er, pos);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
